// File: rtl/shift_normalizer_if.sv
// Handshake bundle between a requester and shift_normalizer.
// master: drives start/din, sees busy/done and the results.
// slave : the normalizer side of the same signals.
interface shift_normalizer_if #(
   parameter int N = 8
);
   localparam int CW = $clog2(N) + 1;

   logic          start;
   logic [N-1:0]  din;
   logic          busy;
   logic          done;
   logic [N-1:0]  shifted;
   logic [CW-1:0] shift_n;
   logic          zero;

   modport master (
      output start, din,
      input  busy, done, shifted, shift_n, zero
   );

   modport slave (
      input  start, din,
      output busy, done, shifted, shift_n, zero
   );
endinterface

// File: rtl/shift_normalizer.sv
// Sequential left-normalizer: shifts one bit per clock until the MSB is set.
// Ports: clk, rst (sync, active-high), bus (slave: start/din in; busy/done/shifted/shift_n/zero out).
module shift_normalizer #(
   parameter int N = 8
) (
   input  logic                clk,
   input  logic                rst,
   shift_normalizer_if.slave   bus
);
   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  w_q, w_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          cnt_full;

   // cnt is wide enough to hold N, so a zero operand stops at exactly N
   assign cnt_full = (cnt_q == CW'(N));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         w_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               w_d     = bus.din;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_q[N-1] || cnt_full) begin
               state_d = S_DONE;
            end else begin
               w_d   = w_q << 1;
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // results come straight from the working registers and hold in IDLE
   assign bus.busy    = (state_q != S_IDLE);
   assign bus.done    = (state_q == S_DONE);
   assign bus.shifted = w_q;
   assign bus.shift_n = cnt_q;
   assign bus.zero    = cnt_full;
endmodule

// File: tb/tb_shift_normalizer.sv
// Randomized and directed bench for shift_normalizer (N=8).
// Expected results come from a leading-zero count over the operand bits.
module tb_shift_normalizer;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   shift_normalizer_if #(.N(8)) bus ();

   shift_normalizer #(.N(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lz(input logic [7:0] d);
      for (int i = 7; i >= 0; i--)
         if (d[i]) return 7 - i;
      return 8;
   endfunction

   task automatic check_clear(input string tag);
      check({tag, ".busy"},    32'(bus.busy),    32'd0);
      check({tag, ".done"},    32'(bus.done),    32'd0);
      check({tag, ".shifted"}, 32'(bus.shifted), 32'd0);
      check({tag, ".shift_n"}, 32'(bus.shift_n), 32'd0);
      check({tag, ".zero"},    32'(bus.zero),    32'd0);
   endtask

   // One operation; optionally pulses a second start at cycle inj_cyc
   task automatic run_op(input logic [7:0] d, input int inj_cyc,
                         input logic [7:0] inj_d, input string tag);
      int          k;
      int          cyc;
      int          extra;
      logic        seen;
      logic [7:0]  exp_sh;
      logic [7:0]  rec;
      k      = lz(d);
      exp_sh = d << k;
      @(negedge clk);
      bus.start = 1'b1;
      bus.din   = d;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.din   = 8'($urandom);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (cyc == inj_cyc) begin
            bus.start = 1'b1;
            bus.din   = inj_d;
         end else begin
            bus.start = 1'b0;
         end
         if (cyc == 1)
            check({tag, ".busy_rise"}, 32'(bus.busy), 32'd1);
         if (bus.done) begin
            seen = 1'b1;
            rec  = bus.shifted >> bus.shift_n;
            check({tag, ".latency"}, 32'(cyc), 32'(k + 2));
            check({tag, ".shifted"}, 32'(bus.shifted), 32'(exp_sh));
            check({tag, ".shift_n"}, 32'(bus.shift_n), 32'(k));
            check({tag, ".zero"},    32'(bus.zero), 32'(d == 8'd0));
            if (d != 8'd0) begin
               check({tag, ".msb"},     32'(bus.shifted[7]), 32'd1);
               check({tag, ".recover"}, 32'(rec), 32'(d));
            end
         end
      end
      if (!seen)
         check({tag, ".timeout"}, 32'(cyc), 32'(k + 2));
      extra = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done) extra++;
         if (i == 0)
            check({tag, ".busy_fall"}, 32'(bus.busy), 32'd0);
      end
      check({tag, ".one_done"}, 32'(extra), 32'd0);
      check({tag, ".hold_sh"},  32'(bus.shifted), 32'(exp_sh));
      check({tag, ".hold_n"},   32'(bus.shift_n), 32'(k));
   endtask

   initial begin
      int         nd;
      logic [7:0] r;
      n_chk     = 0;
      n_err     = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.din   = 8'd0;
      repeat (2) @(negedge clk);
      check_clear("reset");
      rst = 1'b0;

      run_op(8'b0001_0110, 0, 8'd0, "lz3");
      run_op(8'h80, 0, 8'd0, "msb");
      run_op(8'h01, 0, 8'd0, "lsb");
      run_op(8'h00, 0, 8'd0, "zero");
      run_op(8'h04, 2, 8'hFF, "ign_busy");
      run_op(8'h10, 5, 8'hFF, "ign_done");

      // reset two cycles into an operation
      @(negedge clk);
      bus.start = 1'b1;
      bus.din   = 8'h01;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_clear("mid_rst");
      nd = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done) nd++;
      end
      check("mid_rst.no_done", 32'(nd), 32'd0);
      run_op(8'h20, 0, 8'd0, "after_rst");

      // reset wins over a simultaneous start
      @(negedge clk);
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.din   = 8'h80;
      @(negedge clk);
      rst       = 1'b0;
      bus.start = 1'b0;
      check_clear("rst_start");
      @(negedge clk);
      check("rst_start.idle", 32'(bus.busy), 32'd0);

      for (int d = 1; d < 256; d++)
         run_op(8'(d), 0, 8'd0, $sformatf("exh_din=%0h", d));

      for (int i = 0; i < 60; i++) begin
         r = 8'($urandom) >> $urandom_range(0, 8);
         run_op(r, int'($urandom_range(0, 10)), 8'($urandom),
                $sformatf("rnd_din=%0h", r));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/shift_normalizer.md
# shift_normalizer

Sequential left-normalizer for an N-bit word. It shifts the operand left one bit per clock until the MSB is set, then reports the normalized value and the number of shifts taken. It is the inverse end of the barrel-shifter pair: its `shift_n` output is the amount that `shift_right` must apply to `shifted` to recover `din`. It sits in front of the shifters in datapaths that need leading-zero count and normalization, for example float packing or divider pre-scaling.

## Interface
- `n`, default 8: operand width; must be ≥ 2 and need not be a power of two.
- `clk`: input, 1 bit. Single clock; all logic is rising-edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `start`: input, 1 bit. Request normalization of `din`. Sampled only in IDLE.
- `din`: input, n bits. Operand. Sampled on the accepting edge only.
- `busy`: output, 1 bit. High in SHIFT and DONE states.
- `done`: output, 1 bit. One-cycle pulse. Results are valid while it is high, and they hold afterwards.
- `shifted`: output, n bits. Normalized value: `din << shift_n`.
- `shift_n`: output, $clog2(n)+1 bits. Leading-zero count, 0..n.
- `zero`: output, 1 bit. High when `din` was 0. Valid with `done`.

## Operation
- The state register takes IDLE, SHIFT or DONE. Internally there is a working register `w` (n bits) and a count `cnt` ($clog2(n)+1 bits).
- **IDLE with `start`=1:** load `w<=din` and `cnt<=0`, then go to SHIFT. When `start`=0, remain in IDLE.
- **`start` outside IDLE:** ignored. The request is not queued and the latched operand is unaffected.
- **SHIFT:**
  - If `w[n-1]`=1 or `cnt`==n, go to DONE.
  - Otherwise apply `w<=w<<1` (LSB filled with 0) and `cnt<=cnt+1`.
- **DONE:** `done`=1 for exactly this one cycle, then unconditionally go to IDLE. A `start` in the DONE cycle is ignored.
- **Result registers:**
  - `shifted`, `shift_n` and `zero` are driven from `w`, `cnt` and (`cnt`==n).
  - They hold their values until the next accepted `start`.
  - In SHIFT they show intermediate values, which are not valid.
- **din=0:** the block shifts n times, then exits with `shifted`=0, `shift_n`=n and `zero`=1.
- **Invariant for nonzero `din`:**
  - `shifted[n-1]`=1.
  - `shifted >> shift_n` == `din`.
  - `shift_n` equals the number of leading zeros of `din`.
- **Width rule:** `cnt` never exceeds n. There is no wrap-around, because its width of $clog2(n)+1 bits holds n.

## Timing
- **Reset values:** state=IDLE, `busy`=0, `done`=0, `shifted`=0, `shift_n`=0, `zero`=0.
- **Reset mid-operation:** the block returns to IDLE on the next edge. No `done` pulse is produced, and the result registers are cleared.
- **Latency:** let the accepting edge be E0 and k = leading zeros (k=n for din=0). Then:
  - `done` is high during the cycle after edge E0+k+1.
  - Total latency is k+2 cycles from start to the `done` cycle.
  - The best case is `din[n-1]`=1, giving 2 cycles. The worst case is din=0, giving n+2 cycles.
- **`busy`:** rises in the cycle after E0 and falls together with `done`.
- **Back-to-back throughput:** the next `start` can be accepted on the edge that ends the DONE cycle's successor (the IDLE cycle). The minimum period between starts is k+3 cycles.
- **Simultaneous `rst` and `start`:** reset wins.

## Test plan
- din=8'b00010110, start for 1 cycle → `done` after 5 cycles (k=3), `shifted`=8'b10110000, `shift_n`=3, `zero`=0.
- din=8'h80 → `done` 2 cycles after start, `shifted`=8'h80, `shift_n`=0; then din=8'h01 → `shifted`=8'h80, `shift_n`=7, `done` after 9 cycles.
- din=8'h00 → `done` after 10 cycles, `shifted`=0, `shift_n`=8, `zero`=1.
- Start with din=8'h04, then pulse start with din=8'hFF while `busy` → result is `shift_n`=5, `shifted`=8'h80; exactly one `done` pulse.
- Assert `rst` 2 cycles after start with din=8'h01 → no `done` pulse, all outputs 0. A following start with din=8'h20 yields `shift_n`=2, `shifted`=8'h80.
- Exhaustive din=1..255: drive `shifted`/`shift_n` into `shift_right` #(8). The recovered value must equal `din`, `shifted[7]`=1, and `done` must arrive at exactly `shift_n`+2 cycles. Report mismatches with `$time`, `din`, `shift_n` and `shifted`.
